// File: rtl/psram_pattern_tester_pkg.sv
// Shared state codes, pattern mode codes and default LFSR taps for the
// PSRAM pattern tester.
package psram_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_CHECK   = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  localparam logic [1:0] MODE_CONST    = 2'd0;
  localparam logic [1:0] MODE_ADDR_XOR = 2'd1;
  localparam logic [1:0] MODE_WALK     = 2'd2;
  localparam logic [1:0] MODE_LFSR     = 2'd3;

  localparam logic [15:0] LFSR_TAPS_DEFAULT = 16'hB400;

  // States in which the engine is waiting on the controller and may time out.
  function automatic logic is_bus_state(input state_e s);
    return (s == ST_WR_REQ) || (s == ST_WR_WAIT) ||
           (s == ST_RD_REQ) || (s == ST_RD_WAIT);
  endfunction

endpackage

// File: rtl/psram_pattern_tester_if.sv
// Strobe/busy request bus between the pattern tester and the PSRAM controller.
interface psram_pattern_tester_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic              busy;
  logic [DATA_W-1:0] dout;

  modport master (output stb, we, addr, din, input busy, dout);
  modport slave  (input stb, we, addr, din, output busy, dout);
endinterface

// File: rtl/psram_pattern_gen.sv
// Pattern source: holds the LFSR and walking-one state, reseeded at the start
// of each pass and stepped once per word.
module psram_pattern_gen
  import psram_test_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(LFSR_TAPS_DEFAULT)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              reseed_i,
  input  logic              step_i,
  input  logic [1:0]        mode_i,
  input  logic [DATA_W-1:0] seed_i,
  input  logic [DATA_W-1:0] addr_i,
  output logic [DATA_W-1:0] pattern_o
);

  logic [DATA_W-1:0] lfsr_q, lfsr_d;
  logic [DATA_W-1:0] walk_q, walk_d;

  // Next LFSR / walking-one state: reseed wins over step; a zero seed would
  // lock the LFSR so it is replaced by 1.
  always_comb begin
    lfsr_d = lfsr_q;
    walk_d = walk_q;
    if (reseed_i) begin
      lfsr_d = (seed_i == '0) ? DATA_W'(1) : seed_i;
      walk_d = DATA_W'(1);
    end else if (step_i) begin
      lfsr_d = {lfsr_q[DATA_W-2:0], ^(lfsr_q & LFSR_TAPS)};
      walk_d = {walk_q[DATA_W-2:0], walk_q[DATA_W-1]};
    end
  end

  // Pattern state registers.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      lfsr_q <= DATA_W'(1);
      walk_q <= DATA_W'(1);
    end else begin
      lfsr_q <= lfsr_d;
      walk_q <= walk_d;
    end
  end

  // Select the current word's pattern by mode.
  always_comb begin
    unique case (mode_i)
      MODE_CONST:    pattern_o = seed_i;
      MODE_ADDR_XOR: pattern_o = addr_i ^ seed_i;
      MODE_WALK:     pattern_o = walk_q;
      default:       pattern_o = lfsr_q;
    endcase
  end

endmodule

// File: rtl/psram_pattern_tester.sv
// PSRAM self-test engine: writes a pattern over an address range, reads it
// back, counts mismatches and guards every controller handshake with a timeout.
module psram_pattern_tester
  import psram_test_pkg::*;
#(
  parameter int                ADDR_W      = 24,
  parameter int                DATA_W      = 16,
  parameter int                CNT_W       = 16,
  parameter logic [DATA_W-1:0] LFSR_TAPS   = DATA_W'(LFSR_TAPS_DEFAULT),
  parameter int                TIMEOUT_CYC = 1023
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  i_start,
  input  logic [1:0]            i_mode,
  input  logic [DATA_W-1:0]     i_seed,
  input  logic [ADDR_W-1:0]     i_base_addr,
  input  logic [CNT_W-1:0]      i_word_count,
  psram_pattern_tester_if.master bus,
  output logic                  o_running,
  output logic                  o_finished,
  output logic                  o_pass,
  output logic                  o_timeout,
  output logic [CNT_W-1:0]      o_err_count,
  output logic [ADDR_W-1:0]     o_first_err_addr,
  output logic [DATA_W-1:0]     o_first_err_exp,
  output logic [DATA_W-1:0]     o_first_err_got,
  output logic [2:0]            o_state
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  state_e            state_q, state_d;
  logic [TMO_W-1:0]  tmo_q;

  logic [1:0]        mode_q;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  index_q;
  logic [DATA_W-1:0] rd_data_q;

  logic [CNT_W-1:0]  err_q;
  logic [ADDR_W-1:0] ferr_addr_q;
  logic [DATA_W-1:0] ferr_exp_q, ferr_got_q;
  logic              timeout_q;

  logic              start_acc, wr_adv, rd_capture, chk, tmo_hit, last_word, mismatch;
  logic [ADDR_W-1:0] addr_cur;
  logic [DATA_W-1:0] pattern;

  assign addr_cur  = base_q + ADDR_W'(index_q);
  assign last_word = (index_q + CNT_W'(1)) == count_q;
  assign seed_d    = start_acc ? i_seed : seed_q;
  assign mismatch  = chk && (rd_data_q != pattern);

  psram_pattern_gen #(
    .DATA_W    (DATA_W),
    .LFSR_TAPS (LFSR_TAPS)
  ) u_gen (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .reseed_i  (start_acc || (wr_adv && last_word)),
    .step_i    (wr_adv || chk),
    .mode_i    (mode_q),
    .seed_i    (seed_d),
    .addr_i    (addr_cur[DATA_W-1:0]),
    .pattern_o (pattern)
  );

  // FSM state and per-state timeout counter; the counter restarts on every
  // state change so each handshake phase gets the full budget.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || !is_bus_state(state_q)) tmo_q <= '0;
      else                                                tmo_q <= tmo_q + TMO_W'(1);
    end
  end

  // Next-state logic and the per-cycle datapath strobes it implies.
  always_comb begin
    state_d    = state_q;
    start_acc  = 1'b0;
    wr_adv     = 1'b0;
    rd_capture = 1'b0;
    chk        = 1'b0;
    tmo_hit    = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start && !bus.busy) begin
          start_acc = 1'b1;
          state_d   = (i_word_count == '0) ? ST_DONE : ST_WR_REQ;
        end
      end
      ST_WR_REQ:  if (bus.busy) state_d = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (!bus.busy) begin
          wr_adv  = 1'b1;
          state_d = last_word ? ST_RD_REQ : ST_WR_REQ;
        end
      end
      ST_RD_REQ:  if (bus.busy) state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (!bus.busy) begin
          rd_capture = 1'b1;
          state_d    = ST_CHECK;
        end
      end
      ST_CHECK: begin
        chk     = 1'b1;
        state_d = last_word ? ST_DONE : ST_RD_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
    if (is_bus_state(state_q) && (state_d == state_q) &&
        (tmo_q == TMO_W'(TIMEOUT_CYC - 1))) begin
      tmo_hit = 1'b1;
      state_d = ST_DONE;
    end
  end

  // Test parameters, word index and read capture; reset not needed because
  // they are only observed while a test is running.
  always_ff @(posedge clk_i) begin
    if (start_acc) begin
      mode_q  <= i_mode;
      seed_q  <= i_seed;
      base_q  <= i_base_addr;
      count_q <= i_word_count;
      index_q <= '0;
    end else if (wr_adv) begin
      index_q <= last_word ? '0 : index_q + CNT_W'(1);
    end else if (chk) begin
      index_q <= index_q + CNT_W'(1);
    end
    if (rd_capture) rd_data_q <= bus.dout;
  end

  // Result status: saturating error count, first-mismatch capture, timeout flag.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      err_q       <= '0;
      ferr_addr_q <= '0;
      ferr_exp_q  <= '0;
      ferr_got_q  <= '0;
      timeout_q   <= 1'b0;
    end else if (start_acc) begin
      err_q       <= '0;
      ferr_addr_q <= '0;
      ferr_exp_q  <= '0;
      ferr_got_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      if (mismatch) begin
        if (err_q != '1) err_q <= err_q + CNT_W'(1);
        if (err_q == '0) begin
          ferr_addr_q <= addr_cur;
          ferr_exp_q  <= pattern;
          ferr_got_q  <= rd_data_q;
        end
      end
      if (tmo_hit) timeout_q <= 1'b1;
    end
  end

  // Bus request and status outputs decoded from the current state.
  always_comb begin
    bus.stb    = (state_q == ST_WR_REQ) || (state_q == ST_RD_REQ);
    bus.we     = (state_q == ST_WR_REQ);
    bus.addr   = ((state_q == ST_WR_REQ) || (state_q == ST_RD_REQ)) ? addr_cur : '0;
    bus.din    = (state_q == ST_WR_REQ) ? pattern : '0;
    o_running  = (state_q != ST_IDLE) && (state_q != ST_DONE);
    o_finished = (state_q == ST_DONE);
    o_pass     = (state_q == ST_DONE) && (err_q == '0) && !timeout_q;
  end

  assign o_timeout        = timeout_q;
  assign o_err_count      = err_q;
  assign o_first_err_addr = ferr_addr_q;
  assign o_first_err_exp  = ferr_exp_q;
  assign o_first_err_got  = ferr_got_q;
  assign o_state          = state_q;

endmodule

// File: tb/tb_psram_pattern_tester.sv
// Bench for psram_pattern_tester with a mock strobe/busy PSRAM controller.
module tb_psram_pattern_tester;
  import psram_test_pkg::*;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int CW = 16;

  logic          clk;
  logic          rstn;
  logic          start;
  logic [1:0]    mode;
  logic [DW-1:0] seed;
  logic [AW-1:0] base;
  logic [CW-1:0] cnt;
  logic          running, finished, pass, tmo;
  logic [CW-1:0] err_count;
  logic [AW-1:0] ferr_addr;
  logic [DW-1:0] ferr_exp, ferr_got;
  logic [2:0]    state;

  psram_pattern_tester_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  psram_pattern_tester #(
    .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .LFSR_TAPS(16'hB400), .TIMEOUT_CYC(1023)
  ) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .i_start          (start),
    .i_mode           (mode),
    .i_seed           (seed),
    .i_base_addr      (base),
    .i_word_count     (cnt),
    .bus              (bus_if),
    .o_running        (running),
    .o_finished       (finished),
    .o_pass           (pass),
    .o_timeout        (tmo),
    .o_err_count      (err_count),
    .o_first_err_addr (ferr_addr),
    .o_first_err_exp  (ferr_exp),
    .o_first_err_got  (ferr_got),
    .o_state          (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Mock controller state
  logic [DW-1:0] mem [logic [AW-1:0]];
  int            busy_left = 0;
  int            wr_acc    = 0;
  logic          fault_en  = 1'b0;
  logic [AW-1:0] fault_addr = '0;
  int            hang_at   = 0;
  logic [AW-1:0] wr_addr_log [$];
  logic [DW-1:0] wr_data_log [$];

  // Mock: acts on the falling edge, busy for 4 cycles per request, optional
  // stuck-high bit 3 at one address and optional refusal of the Nth write.
  initial begin
    logic [AW-1:0] a;
    bus_if.busy = 1'b0;
    bus_if.dout = '0;
    forever begin
      @(negedge clk);
      if (bus_if.busy) begin
        busy_left--;
        if (busy_left == 0) bus_if.busy = 1'b0;
      end else if (bus_if.stb && !(hang_at != 0 && bus_if.we && wr_acc == hang_at - 1)) begin
        a = bus_if.addr;
        if (bus_if.we) begin
          mem[a] = bus_if.din;
          wr_addr_log.push_back(a);
          wr_data_log.push_back(bus_if.din);
          wr_acc++;
        end else begin
          bus_if.dout = (mem.exists(a) ? mem[a] : 16'h0000) |
                        ((fault_en && a == fault_addr) ? 16'h0008 : 16'h0000);
        end
        bus_if.busy = 1'b1;
        busy_left   = 4;
      end
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] seed;
    logic [23:0] base;
    logic [15:0] count;
    logic        fault;
    logic [23:0] faddr;
    int          hang;
    logic        exp_pass;
    logic        exp_tmo;
    logic [15:0] exp_err;
    logic [23:0] exp_faddr;
    logic [15:0] exp_fexp;
    logic [15:0] exp_fgot;
    int          exp_wr;
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input int i);
    vec_t v;
    int   guard;
    int   stb_hi;
    logic [AW-1:0] ea [4];
    logic [DW-1:0] ed [4];
    int            li [6];
    logic [DW-1:0] lv [6];
    v = vecs[i];
    guard = 0;
    while (bus_if.busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk($sformatf("v%0d_bus_idle", i), {31'd0, bus_if.busy}, 32'd0);
    @(negedge clk);
    fault_en = v.fault; fault_addr = v.faddr; hang_at = v.hang; wr_acc = 0;
    wr_addr_log.delete(); wr_data_log.delete();
    mode = v.mode; seed = v.seed; base = v.base; cnt = v.count; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (v.count == 0) begin
      chk($sformatf("v%0d_fin_next_cycle", i), {30'd0, finished, pass}, 32'd3);
      chk($sformatf("v%0d_no_stb", i), {31'd0, bus_if.stb}, 32'd0);
    end else begin
      chk($sformatf("v%0d_stb_after_start", i), {30'd0, bus_if.stb, running}, 32'd3);
      chk($sformatf("v%0d_first_addr", i), {8'd0, bus_if.addr}, {8'd0, v.base});
    end
    guard = 0; stb_hi = 0;
    while (!finished && guard < 4000) begin
      if (bus_if.stb && wr_acc == 2) stb_hi++;
      @(posedge clk); #1;
      guard++;
    end
    chk($sformatf("v%0d_finished", i), {31'd0, finished}, 32'd1);
    chk($sformatf("v%0d_pass", i), {31'd0, pass}, {31'd0, v.exp_pass});
    chk($sformatf("v%0d_timeout", i), {31'd0, tmo}, {31'd0, v.exp_tmo});
    chk($sformatf("v%0d_err_count", i), {16'd0, err_count}, {16'd0, v.exp_err});
    chk($sformatf("v%0d_ferr_addr", i), {8'd0, ferr_addr}, {8'd0, v.exp_faddr});
    chk($sformatf("v%0d_ferr_exp", i), {16'd0, ferr_exp}, {16'd0, v.exp_fexp});
    chk($sformatf("v%0d_ferr_got", i), {16'd0, ferr_got}, {16'd0, v.exp_fgot});
    chk($sformatf("v%0d_idle_bus", i), {29'd0, running, bus_if.stb, bus_if.we}, 32'd0);
    chk($sformatf("v%0d_state", i), {29'd0, state}, 32'd6);
    chk($sformatf("v%0d_writes", i), wr_addr_log.size(), v.exp_wr);
    if (v.hang != 0)
      chk($sformatf("v%0d_stb_cycles", i), stb_hi, 1023);
    if (i == 0) begin
      for (int j = 0; j < 8; j++) begin
        if (j < wr_addr_log.size()) begin
          chk($sformatf("v0_addr%0d", j), {8'd0, wr_addr_log[j]}, 32'h00ABCDEF + j);
          chk($sformatf("v0_data%0d", j), {16'd0, wr_data_log[j]},
              {16'd0, (16'hCDEF + 16'(j)) ^ 16'h00FF});
        end
      end
    end
    if (i == 2) begin
      ea = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
      ed = '{16'h0001, 16'h0002, 16'h0004, 16'h0008};
      for (int j = 0; j < 4; j++) begin
        if (j < wr_addr_log.size()) begin
          chk($sformatf("v2_addr%0d", j), {8'd0, wr_addr_log[j]}, {8'd0, ea[j]});
          chk($sformatf("v2_data%0d", j), {16'd0, wr_data_log[j]}, {16'd0, ed[j]});
        end
      end
    end
    if (i == 5) begin
      li = '{0, 1, 10, 11, 13, 14};
      lv = '{16'h0001, 16'h0002, 16'h0400, 16'h0801, 16'h2005, 16'h400B};
      for (int j = 0; j < 6; j++) begin
        if (li[j] < wr_data_log.size())
          chk($sformatf("v5_lfsr%0d", li[j]), {16'd0, wr_data_log[li[j]]}, {16'd0, lv[j]});
      end
    end
  endtask

  initial begin
    int guard;
    vecs[0] = '{2'd1, 16'h00FF, 24'hABCDEF, 16'd8,  1'b0, 24'h0,      0, 1'b1, 1'b0, 16'd0, 24'h0, 16'h0, 16'h0,    8};
    vecs[1] = '{2'd0, 16'h0000, 24'h000000, 16'd4,  1'b1, 24'h000002, 0, 1'b0, 1'b0, 16'd1, 24'h2, 16'h0, 16'h0008, 4};
    vecs[2] = '{2'd2, 16'h0000, 24'hFFFFFE, 16'd4,  1'b0, 24'h0,      0, 1'b1, 1'b0, 16'd0, 24'h0, 16'h0, 16'h0,    4};
    vecs[3] = '{2'd0, 16'h1234, 24'h000100, 16'd8,  1'b0, 24'h0,      3, 1'b0, 1'b1, 16'd0, 24'h0, 16'h0, 16'h0,    2};
    vecs[4] = '{2'd1, 16'h5555, 24'h000200, 16'd0,  1'b0, 24'h0,      0, 1'b1, 1'b0, 16'd0, 24'h0, 16'h0, 16'h0,    0};
    vecs[5] = '{2'd3, 16'h0000, 24'h000040, 16'd20, 1'b0, 24'h0,      0, 1'b1, 1'b0, 16'd0, 24'h0, 16'h0, 16'h0,    20};

    rstn = 1'b0; start = 1'b0; mode = '0; seed = '0; base = '0; cnt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_flags", {27'd0, running, finished, pass, tmo, bus_if.stb}, 32'd0);
    chk("rst_bus", {7'd0, bus_if.we, bus_if.addr}, 32'd0);
    chk("rst_err", {err_count, ferr_exp}, 32'd0);
    chk("rst_ferr", {ferr_got, ferr_addr[15:0]}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i);

    // Fault on the first LFSR word, then reset while waiting on a read.
    @(negedge clk);
    fault_en = 1'b1; fault_addr = 24'h000040; hang_at = 0;
    mode = 2'd3; seed = 16'h0000; base = 24'h000040; cnt = 16'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (err_count == 0 && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("rst_seq_err_seen", {16'd0, err_count}, 32'd1);
    chk("rst_seq_ferr", {ferr_exp, ferr_got}, {16'h0001, 16'h0009});
    guard = 0;
    while (state != 3'd4 && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("rst_seq_in_rd_wait", {29'd0, state}, 32'd4);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("midrst_state", {29'd0, state}, 32'd0);
    chk("midrst_flags", {27'd0, running, finished, pass, tmo, bus_if.stb}, 32'd0);
    chk("midrst_bus", {7'd0, bus_if.we, bus_if.addr}, 32'd0);
    chk("midrst_err", {err_count, ferr_exp}, 32'd0);
    chk("midrst_ferr", {ferr_got, ferr_addr[15:0]}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
